// File: rtl/trace_stream_arbiter.sv
// Round-robin arbiter between register-write and memory-write trace sources.
// The winning record is latched and serialized one ASCII character per clock.
module trace_stream_arbiter #(
    parameter logic [7:0] IDLE_CHAR = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_req,
    input  logic [15:0] reg_time,
    input  logic [31:0] reg_pc,
    input  logic [4:0]  reg_num,
    input  logic [31:0] reg_data,
    output logic        reg_ack,
    input  logic        mem_req,
    input  logic [15:0] mem_time,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic        mem_ack,
    input  logic        char_stall,
    output logic [7:0]  char_out,
    output logic        char_valid,
    output logic        busy,
    output logic [15:0] sent_count
);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_SEND   = 1'b1;
    localparam logic [5:0] REG_LAST = 6'd29;
    localparam logic [5:0] MEM_LAST = 6'd35;

    logic [0:0]  state, state_n;
    logic [5:0]  idx, idx_n, nidx, last_idx;
    logic        last_mem, last_mem_n, rec_mem, rec_mem_n, grant_mem;
    logic [15:0] rec_time, rec_time_n, count_n;
    logic [31:0] rec_pc, rec_pc_n, rec_addr, rec_addr_n, rec_data, rec_data_n;
    logic [7:0]  char_n, seq_char;
    logic        valid_n, busy_n, reg_ack_n, mem_ack_n;
    logic [4:0]  num, tens_val;
    logic [3:0]  tens, units;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
    endfunction

    function automatic logic [7:0] bcd_char(input logic [3:0] n);
        return (n > 4'd9) ? 8'h39 : 8'h30 + {4'h0, n};
    endfunction

    function automatic logic [3:0] nib32(input logic [31:0] w, input logic [2:0] pos);
        logic [4:0] base;
        base = {3'(3'd7 - pos), 2'b00};
        return w[base +: 4];
    endfunction

    function automatic logic [3:0] nib16(input logic [15:0] w, input logic [1:0] pos);
        logic [3:0] base;
        base = {2'(2'd3 - pos), 2'b00};
        return w[base +: 4];
    endfunction

    // Register number split into two decimal digits.
    always_comb begin
        num      = rec_addr[4:0];
        tens     = 4'd0;
        tens_val = 5'd0;
        if (num >= 5'd30) begin
            tens = 4'd3; tens_val = 5'd30;
        end else if (num >= 5'd20) begin
            tens = 4'd2; tens_val = 5'd20;
        end else if (num >= 5'd10) begin
            tens = 4'd1; tens_val = 5'd10;
        end
        units = 4'(num - tens_val);
    end

    // Character at the index that follows the current one.
    always_comb begin
        nidx     = idx + 6'd1;
        last_idx = rec_mem ? MEM_LAST : REG_LAST;
        seq_char = 8'h23;
        if (nidx <= 6'd4)       seq_char = bcd_char(nib16(rec_time, 2'(nidx - 6'd1)));
        else if (nidx == 6'd5)  seq_char = 8'h40;
        else if (nidx <= 6'd13) seq_char = hex_char(nib32(rec_pc, 3'(nidx - 6'd6)));
        else if (nidx == 6'd14) seq_char = 8'h3a;
        else if (nidx == 6'd15) seq_char = 8'h20;
        else if (nidx == 6'd16) seq_char = rec_mem ? 8'h2a : 8'h24;
        else if (!rec_mem) begin
            if (nidx == 6'd17)      seq_char = bcd_char(tens);
            else if (nidx == 6'd18) seq_char = bcd_char(units);
            else if (nidx == 6'd19) seq_char = 8'h3c;
            else if (nidx == 6'd20) seq_char = 8'h3d;
            else if (nidx <= 6'd28) seq_char = hex_char(nib32(rec_data, 3'(nidx - 6'd21)));
        end else begin
            if (nidx <= 6'd24)      seq_char = hex_char(nib32(rec_addr, 3'(nidx - 6'd17)));
            else if (nidx == 6'd25) seq_char = 8'h3c;
            else if (nidx == 6'd26) seq_char = 8'h3d;
            else if (nidx <= 6'd34) seq_char = hex_char(nib32(rec_data, 3'(nidx - 6'd27)));
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        last_mem_n = last_mem;
        rec_mem_n  = rec_mem;
        rec_time_n = rec_time;
        rec_pc_n   = rec_pc;
        rec_addr_n = rec_addr;
        rec_data_n = rec_data;
        char_n     = char_out;
        valid_n    = char_valid;
        busy_n     = busy;
        count_n    = sent_count;
        reg_ack_n  = 1'b0;
        mem_ack_n  = 1'b0;
        grant_mem  = mem_req && (!reg_req || !last_mem);
        case (state)
            S_IDLE: begin
                char_n  = IDLE_CHAR;
                valid_n = 1'b0;
                busy_n  = 1'b0;
                if (!char_stall && (reg_req || mem_req)) begin
                    state_n    = S_SEND;
                    idx_n      = 6'd0;
                    last_mem_n = grant_mem;
                    rec_mem_n  = grant_mem;
                    rec_time_n = grant_mem ? mem_time : reg_time;
                    rec_pc_n   = grant_mem ? mem_pc : reg_pc;
                    rec_addr_n = grant_mem ? mem_addr : {27'd0, reg_num};
                    rec_data_n = grant_mem ? mem_data : reg_data;
                    char_n     = 8'h5e;
                    valid_n    = 1'b1;
                    busy_n     = 1'b1;
                    reg_ack_n  = !grant_mem;
                    mem_ack_n  = grant_mem;
                end
            end
            S_SEND: begin
                if (!char_stall) begin
                    if (idx == last_idx) begin
                        state_n = S_IDLE;
                        idx_n   = 6'd0;
                        char_n  = IDLE_CHAR;
                        valid_n = 1'b0;
                        busy_n  = 1'b0;
                        count_n = sent_count + 16'd1;
                    end else begin
                        idx_n  = nidx;
                        char_n = seq_char;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= 6'd0;
            last_mem   <= 1'b1;
            rec_mem    <= 1'b0;
            rec_time   <= 16'd0;
            rec_pc     <= 32'd0;
            rec_addr   <= 32'd0;
            rec_data   <= 32'd0;
            char_out   <= IDLE_CHAR;
            char_valid <= 1'b0;
            busy       <= 1'b0;
            reg_ack    <= 1'b0;
            mem_ack    <= 1'b0;
            sent_count <= 16'd0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            last_mem   <= last_mem_n;
            rec_mem    <= rec_mem_n;
            rec_time   <= rec_time_n;
            rec_pc     <= rec_pc_n;
            rec_addr   <= rec_addr_n;
            rec_data   <= rec_data_n;
            char_out   <= char_n;
            char_valid <= valid_n;
            busy       <= busy_n;
            reg_ack    <= reg_ack_n;
            mem_ack    <= mem_ack_n;
            sent_count <= count_n;
        end
    end
endmodule

// File: tb/tb_trace_stream_arbiter.sv
// Randomized bench for trace_stream_arbiter; expected records are built as
// formatted strings from the source fields and compared character by character.
module tb_trace_stream_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        reg_req, mem_req, reg_ack, mem_ack;
    logic [15:0] reg_time, mem_time, sent_count;
    logic [31:0] reg_pc, reg_data, mem_pc, mem_addr, mem_data;
    logic [4:0]  reg_num;
    logic        char_stall, char_valid, busy;
    logic [7:0]  char_out;

    int checks = 0;
    int errors = 0;
    bit last_mem = 1'b1;
    int exp_count = 0;
    bit keep_r = 1'b0;
    bit keep_m = 1'b0;
    bit win;

    always #5 clk = ~clk;

    trace_stream_arbiter dut (
        .clk(clk), .reset(reset),
        .reg_req(reg_req), .reg_time(reg_time), .reg_pc(reg_pc), .reg_num(reg_num),
        .reg_data(reg_data), .reg_ack(reg_ack),
        .mem_req(mem_req), .mem_time(mem_time), .mem_pc(mem_pc), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_ack(mem_ack),
        .char_stall(char_stall), .char_out(char_out), .char_valid(char_valid),
        .busy(busy), .sent_count(sent_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic string time_str(input logic [15:0] t);
        string s;
        int d;
        s = "";
        for (int i = 3; i >= 0; i--) begin
            d = int'(t[i*4 +: 4]);
            if (d > 9) d = 9;
            s = {s, $sformatf("%0d", d)};
        end
        return s;
    endfunction

    function automatic string reg_rec(input logic [15:0] t, input logic [31:0] pc,
                                      input logic [4:0] n, input logic [31:0] d);
        return $sformatf("^%s@%08h: $%02d<=%08h#", time_str(t), pc, n, d);
    endfunction

    function automatic string mem_rec(input logic [15:0] t, input logic [31:0] pc,
                                      input logic [31:0] a, input logic [31:0] d);
        return $sformatf("^%s@%08h: *%08h<=%08h#", time_str(t), pc, a, d);
    endfunction

    task automatic rand_reg();
        reg_time = 16'($urandom); reg_pc = $urandom; reg_num = 5'($urandom); reg_data = $urandom;
    endtask

    task automatic rand_mem();
        mem_time = 16'($urandom); mem_pc = $urandom; mem_addr = $urandom; mem_data = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b1; reg_req = 1'b0; mem_req = 1'b0; char_stall = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        last_mem = 1'b1;
        exp_count = 0;
    endtask

    // mode 0: no stall, 1: random stall, 2: stall three cycles on '@'
    task automatic do_record(input int mode, input bit chk_gap, output bit win_mem);
        string exp;
        logic [7:0] q[$];
        int acks_r, acks_m, cyc, gap, at_cnt, stalls;
        bit started, done, s;
        acks_r = 0; acks_m = 0; cyc = 0; gap = 0; at_cnt = 0; stalls = 0;
        started = 1'b0; done = 1'b0;
        win_mem = mem_req && (!reg_req || !last_mem);
        exp = win_mem ? mem_rec(mem_time, mem_pc, mem_addr, mem_data)
                      : reg_rec(reg_time, reg_pc, reg_num, reg_data);
        while (!done && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (char_valid && !started) begin
                check_val("start_busy", 32'(busy), 1);
                check_val("start_ack", 32'(win_mem ? mem_ack : reg_ack), 1);
            end
            if (reg_ack) begin
                acks_r++;
                if (keep_r) rand_reg(); else reg_req = 1'b0;
            end
            if (mem_ack) begin
                acks_m++;
                if (keep_m) rand_mem(); else mem_req = 1'b0;
            end
            if (char_valid) started = 1'b1;
            else if (!started) gap++;
            if (char_valid && char_out == 8'h40) at_cnt++;
            case (mode)
                1: s = ($urandom_range(0, 3) == 0);
                2: s = char_valid && char_out == 8'h40 && stalls < 3;
                default: s = 1'b0;
            endcase
            if (s) stalls++;
            char_stall = s;
            if (char_valid && !s) begin
                q.push_back(char_out);
                if (char_out == 8'h23) done = 1'b1;
            end
        end
        if (!done) check_val("timeout", 0, 1);
        check_val("reg_acks", 32'(acks_r), win_mem ? 0 : 1);
        check_val("mem_acks", 32'(acks_m), win_mem ? 1 : 0);
        check_val("rec_len", 32'(q.size()), 32'(exp.len()));
        for (int i = 0; i < exp.len(); i++)
            check_val($sformatf("char%0d", i), (i < q.size()) ? 32'(q[i]) : 32'hffff_ffff,
                      32'(8'(exp[i])));
        if (mode == 2) check_val("at_hold", 32'(at_cnt), 4);
        if (chk_gap) check_val("gap", 32'(gap), 0);
        last_mem = win_mem;
        exp_count++;
        @(negedge clk);
        check_val("idle_valid", 32'(char_valid), 0);
        check_val("idle_busy", 32'(busy), 0);
        check_val("count", 32'(sent_count), 32'(16'(exp_count)));
    endtask

    initial begin
        rand_reg(); rand_mem();
        do_reset();
        check_val("rst_char", 32'(char_out), 0);
        check_val("rst_valid", 32'(char_valid), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_acks", 32'({reg_ack, mem_ack}), 0);
        check_val("rst_count", 32'(sent_count), 0);

        // Directed register record
        reg_time = 16'h0012; reg_pc = 32'h00003000; reg_num = 5'd5; reg_data = 32'hdeadbeef;
        reg_req = 1'b1;
        do_record(0, 1'b1, win);
        check_val("dir_reg_win", 32'(win), 0);

        // Directed memory record
        mem_time = 16'h9999; mem_pc = 32'h0000300c; mem_addr = 32'h0000abcd; mem_data = 32'h0;
        mem_req = 1'b1;
        do_record(0, 1'b1, win);
        check_val("dir_mem_win", 32'(win), 1);

        // Both held from reset: strict alternation, back to back
        do_reset();
        keep_r = 1'b1; keep_m = 1'b1;
        rand_reg(); rand_mem(); reg_req = 1'b1; mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_record(0, i > 0, win);
            check_val($sformatf("order%0d", i), 32'(win), 32'(i % 2));
        end
        reg_req = 1'b0; mem_req = 1'b0; keep_r = 1'b0; keep_m = 1'b0;
        @(negedge clk);

        // Stall while '@' is presented
        rand_reg(); reg_req = 1'b1;
        do_record(2, 1'b0, win);

        // Reset while the 10th character is on the output
        rand_reg(); reg_req = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 50 && seen < 10; c++) begin
                @(negedge clk);
                if (reg_ack) reg_req = 1'b0;
                if (char_valid) seen++;
            end
            check_val("rst_mid_seen", 32'(seen), 10);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            last_mem = 1'b1;
            exp_count = 0;
            check_val("rst_mid_valid", 32'(char_valid), 0);
            check_val("rst_mid_busy", 32'(busy), 0);
            check_val("rst_mid_count", 32'(sent_count), 0);
        end
        rand_reg(); reg_req = 1'b1;
        do_record(0, 1'b0, win);

        // reg_num 31 and a non-decimal time nibble
        reg_time = 16'h0c12; reg_pc = 32'h12345678; reg_num = 5'd31; reg_data = 32'h00ff00aa;
        reg_req = 1'b1;
        do_record(0, 1'b1, win);

        // Random traffic with random stalls
        for (int n = 0; n < 25; n++) begin
            keep_r = ($urandom_range(0, 2) == 0);
            keep_m = ($urandom_range(0, 2) == 0);
            if (!reg_req && $urandom_range(0, 1) == 1) begin rand_reg(); reg_req = 1'b1; end
            if (!mem_req && $urandom_range(0, 1) == 1) begin rand_mem(); mem_req = 1'b1; end
            if (!reg_req && !mem_req) begin rand_reg(); reg_req = 1'b1; end
            do_record(int'($urandom_range(0, 1)), 1'b0, win);
        end
        reg_req = 1'b0; mem_req = 1'b0;
        repeat (3) @(negedge clk);
        check_val("end_valid", 32'(char_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
